// File: rtl/sr_pkg.sv
// sr_pkg: op encodings and FSM states shared by the SR bank controller
package sr_pkg;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_SET = 2'b01, OP_CLR = 2'b10, OP_TGL = 2'b11} op_t;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_DRIVE = 2'b01, ST_CHECK = 2'b10} state_t;
endpackage

// File: rtl/rr_arb.sv
// rr_arb: combinational round-robin pick of the first request at or after ptr
module rr_arb #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id,
  output logic         any
);
  logic [W-1:0] k;
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    any = 1'b0;
    k = '0;
    for (int i = 0; i < N; i++) begin
      k = W'((int'(ptr) + i) % N);
      if (!any && req[k]) begin
        any = 1'b1;
        gnt_id = k;
        gnt[k] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sr_bank_ctrl.sv
// sr_bank_ctrl: arbitrates requesters into one-hot SR pulses on a flag bank and checks the result
module sr_bank_ctrl
  import sr_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NFF = 8,
  parameter int IDXW = 3,
  localparam int IW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [IDXW*NREQ-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  output logic [NFF-1:0]       s_vec,
  output logic [NFF-1:0]       r_vec,
  input  logic [NFF-1:0]       q_vec,
  output logic                 busy,
  output logic                 done,
  output logic [IW-1:0]        done_id,
  output logic                 err
);
  state_t state, state_n;
  logic [IW-1:0] ptr, g_id, id;
  logic [NREQ-1:0] gnt;
  logic any, take, g_bad, g_nop, g_set, chk, exp_q, done_q, err_q;
  logic [1:0] g_op;
  logic [IDXW-1:0] g_idx, idx;
  logic [NFF-1:0] hot;
  rr_arb #(.N(NREQ)) u_arb (.req(req_valid), .ptr(ptr), .gnt(gnt), .gnt_id(g_id), .any(any));
  always_comb begin
    g_op = '0;
    g_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        g_op = req_op[2*i +: 2];
        g_idx = req_idx[IDXW*i +: IDXW];
      end
  end
  assign hot = NFF'(1) << g_idx;
  assign g_bad = int'(g_idx) >= NFF;
  assign g_nop = g_op == OP_NOP || g_bad;
  assign g_set = g_op == OP_SET || (g_op == OP_TGL && !(|(q_vec & hot)));
  assign take = state == ST_IDLE && any && !reset;
  assign req_ready = take ? gnt : '0;
  assign chk = state == ST_CHECK;
  assign busy = state != ST_IDLE;
  assign done = done_q | chk;
  assign done_id = done ? id : '0;
  assign err = err_q | (chk && ((|(q_vec & (NFF'(1) << idx))) != exp_q));
  always_comb state_n = state == ST_DRIVE ? ST_CHECK : (take && !g_nop) ? ST_DRIVE : ST_IDLE;
  always_ff @(posedge clk) state <= reset ? ST_IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      id <= '0;
      idx <= '0;
      exp_q <= 1'b0;
      s_vec <= '0;
      r_vec <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      s_vec <= '0;
      r_vec <= '0;
      done_q <= take && g_nop;
      err_q <= take && g_bad;
      if (take) begin
        ptr <= int'(g_id) == NREQ - 1 ? '0 : g_id + 1'b1;
        id <= g_id;
        idx <= g_idx;
        exp_q <= g_set;
        if (!g_nop) begin
          s_vec <= g_set ? hot : '0;
          r_vec <= g_set ? '0 : hot;
        end
      end
    end
  end
endmodule

// File: tb/tb_sr_bank_ctrl.sv
// tb_sr_bank_ctrl: directed and random stimulus against a cycle-schedule model of the controller
module tb_sr_bank_ctrl;
  localparam int NREQ = 4;
  localparam int NFF = 8;
  localparam int IDXW = 4;
  logic clk = 1'b0;
  logic reset;
  logic [NREQ-1:0] req_valid, req_ready, got;
  logic [2*NREQ-1:0] req_op;
  logic [IDXW*NREQ-1:0] req_idx;
  logic [NFF-1:0] s_vec, r_vec, q_vec, fq, stuck;
  logic busy, done, err;
  logic [1:0] done_id;
  int errors = 0, checks = 0;
  sr_bank_ctrl #(.NREQ(NREQ), .NFF(NFF), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
    .req_ready(req_ready), .s_vec(s_vec), .r_vec(r_vec), .q_vec(q_vec),
    .busy(busy), .done(done), .done_id(done_id), .err(err));
  always #5 clk = ~clk;
  always_ff @(posedge clk) fq <= reset ? '0 : (fq | s_vec) & ~r_vec;
  assign q_vec = fq & ~stuck;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int i, input logic [1:0] op, input logic [3:0] ix);
    req_valid[i] = 1'b1;
    req_op[2*i +: 2] = op;
    req_idx[4*i +: 4] = ix;
  endtask
  // model: each grant schedules what the outputs must show one and two cycles later
  logic [NFF-1:0] es[8], er[8], mq, obs;
  bit eb[8], ed[8], ee[8], ck[8], cx[8], on, mbad, mset;
  int ci[8], cid[8], c, sl, gx, mptr;
  logic [1:0] mop;
  logic [3:0] mix;
  logic [NREQ-1:0] erdy;
  initial begin
    c = 0; mptr = 0; on = 0; mq = '0;
    for (int k = 0; k < 8; k++) begin es[k] = '0; er[k] = '0; eb[k] = 0; ed[k] = 0; ee[k] = 0; ck[k] = 0; cx[k] = 0; ci[k] = 0; cid[k] = 0; end
    forever begin
      @(negedge clk);
      sl = c % 8;
      obs = mq & ~stuck;
      gx = -1;
      if (!eb[sl] && !reset)
        for (int k = 0; k < NREQ; k++)
          if (gx < 0 && req_valid[(mptr + k) % NREQ]) gx = (mptr + k) % NREQ;
      erdy = gx >= 0 ? NREQ'(1) << gx : '0;
      if (on) begin
        check("req_ready", req_ready, erdy);
        check("s_vec", s_vec, es[sl]);
        check("r_vec", r_vec, er[sl]);
        check("busy", busy, eb[sl]);
        check("done", done, ed[sl]);
        check("done_id", done_id, ed[sl] ? cid[sl] : 0);
        check("err", err, ee[sl] | (ck[sl] && obs[ci[sl]] != cx[sl]));
        check("q_vec", q_vec, obs);
        check("s_and_r", s_vec & r_vec, 0);
        check("sr_onehot", $countones(s_vec | r_vec) <= 1, 1);
      end
      mq = (mq | es[sl]) & ~er[sl];
      es[sl] = '0; er[sl] = '0; eb[sl] = 0; ed[sl] = 0; ee[sl] = 0; ck[sl] = 0;
      if (reset) begin
        for (int k = 0; k < 8; k++) begin es[k] = '0; er[k] = '0; eb[k] = 0; ed[k] = 0; ee[k] = 0; ck[k] = 0; end
        mptr = 0; mq = '0; on = 1;
      end else if (gx >= 0) begin
        mop = req_op[2*gx +: 2];
        mix = req_idx[4*gx +: 4];
        mptr = (gx + 1) % NREQ;
        mbad = int'(mix) >= NFF;
        if (mop == 2'b00 || mbad) begin
          ed[(c+1)%8] = 1; cid[(c+1)%8] = gx; ee[(c+1)%8] = mbad;
        end else begin
          mset = mop == 2'b01 || (mop == 2'b11 && !obs[mix]);
          if (mset) es[(c+1)%8][mix] = 1'b1; else er[(c+1)%8][mix] = 1'b1;
          eb[(c+1)%8] = 1; eb[(c+2)%8] = 1; ed[(c+2)%8] = 1; cid[(c+2)%8] = gx;
          ck[(c+2)%8] = 1; ci[(c+2)%8] = int'(mix); cx[(c+2)%8] = mset;
        end
      end
      c++;
    end
  end
  int gid[8], gcy[8], n;
  initial begin
    reset = 1; req_valid = '0; req_op = '0; req_idx = '0; stuck = '0;
    tick(); tick(); reset = 0;
    drive(0, 2'b01, 3);
    @(negedge clk); check("t1_ready", req_ready, 4'b0001);
    tick(); req_valid = '0;
    @(negedge clk); check("t1_s", s_vec, 8'h08); check("t1_r", r_vec, 8'h00);
    tick();
    @(negedge clk); check("t1_done", done, 1); check("t1_id", done_id, 0); check("t1_err", err, 0); check("t1_q3", q_vec[3], 1);
    tick(); reset = 1; tick(); reset = 0;
    for (int i = 0; i < NREQ; i++) drive(i, 2'b11, 4'(i));
    n = 0;
    for (int t = 0; t < 40 && n < 8; t++) begin
      @(negedge clk);
      if (|req_ready) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid[n] = i;
        gcy[n] = t;
        if (n == 4) check("t2_q_pass1", q_vec, 8'h0F);
        n++;
      end
      if (n < 8) tick();
    end
    check("t2_grants", n, 8);
    for (int k = 0; k < 5; k++) check("t2_order", gid[k], k % 4);
    for (int k = 0; k < 4; k++) check("t2_spacing", gcy[k+1] - gcy[k], 3);
    tick(); req_valid = '0; tick();
    @(negedge clk); check("t2_q_pass2", q_vec, 8'h00);
    tick();
    drive(2, 2'b10, 9);
    @(negedge clk); check("t3_ready", req_ready, 4'b0100);
    tick(); req_valid = '0;
    @(negedge clk); check("t3_done", done, 1); check("t3_err", err, 1); check("t3_id", done_id, 2); check("t3_sr", s_vec | r_vec, 0);
    tick();
    stuck = 8'h20; drive(0, 2'b01, 5);
    @(negedge clk); check("t4_ready", req_ready, 4'b0001);
    tick(); req_valid = '0; tick();
    @(negedge clk); check("t4_done", done, 1); check("t4_err", err, 1);
    tick(); stuck = '0;
    drive(1, 2'b01, 1);
    @(negedge clk); check("t5_ready", req_ready, 4'b0010);
    tick(); req_valid = '0; reset = 1;
    @(negedge clk); check("t5_s", s_vec, 8'h02);
    tick(); reset = 0;
    @(negedge clk); check("t5_idle", {req_ready, s_vec, r_vec, busy, done, err}, 0);
    tick(); drive(0, 2'b01, 0); drive(2, 2'b01, 2);
    @(negedge clk); check("t5_nodone", done, 0); check("t5_ptr0", req_ready, 4'b0001);
    tick(); req_valid = '0; tick(); tick();
    drive(1, 2'b00, 0); drive(3, 2'b01, 4);
    @(negedge clk); check("t6_ready1", req_ready, 4'b0010);
    tick(); req_valid[1] = 1'b0;
    @(negedge clk); check("t6_done", done, 1); check("t6_id", done_id, 1); check("t6_ready3", req_ready, 4'b1000);
    tick(); req_valid = '0; tick(); tick();
    got = '0;
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (got[i]) req_valid[i] = 1'b0;
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) drive(i, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 10)));
        end else if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
      end
      reset = $urandom_range(0, 149) == 0;
      @(negedge clk); got = req_ready;
      tick();
    end
    req_valid = '0; reset = 0;
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
